// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: N-digit multiplexed 7-segment driver.
//   Hex mode shows value nibbles directly. Decimal mode converts the binary value
//   with a sequential double-dabble, one step per clock, under a load/ready handshake.
//   Per-digit decimal points, sticky overflow ('-' on every digit), selectable polarity.
//   Optional build macro: SEG_LEADING_ZERO_BLANK_EN blanks leading zeros in decimal mode.
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS    = 4,
   parameter int SCAN_DIV_BITS = 16,
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    mode_dec,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic                    load,
   output logic                    ready,
   output logic [6:0]              display,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   digit
);

   localparam int W  = 4 * NUM_DIGITS;
   localparam int CW = $clog2(W + 1);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_CONV   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   logic [1:0]               state_q, state_d;
   logic [W-1:0]             bin_q, bin_d;
   logic [W-1:0]             bcd_q, bcd_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic                     ovf_q, ovf_d;
   logic [W-1:0]             shown_q, shown_d;
   logic [NUM_DIGITS-1:0]    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]    dpl_q, dpl_d;
   logic                     overflow_q, overflow_d;
   logic                     dec_q, dec_d;

   logic [SCAN_DIV_BITS-1:0] div_q;
   logic [IW-1:0]            idx_q;
   logic                     started_q;

   logic [W-1:0]             bcd_adj;
   logic [W-1:0]             bcd_step;
   logic [W-1:0]             bin_step;
   logic                     carry;

   logic [3:0]               cur_nib;
   logic                     cur_dp;
   logic                     blank;
   logic [6:0]               seg_ah;
   logic                     dp_ah;
   logic [NUM_DIGITS-1:0]    dig_ah;

   // Standard active-high glyphs, bit order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: glyph = 7'h3F;
         4'h1: glyph = 7'h06;
         4'h2: glyph = 7'h5B;
         4'h3: glyph = 7'h4F;
         4'h4: glyph = 7'h66;
         4'h5: glyph = 7'h6D;
         4'h6: glyph = 7'h7D;
         4'h7: glyph = 7'h07;
         4'h8: glyph = 7'h7F;
         4'h9: glyph = 7'h6F;
         4'hA: glyph = 7'h77;
         4'hB: glyph = 7'h7C;
         4'hC: glyph = 7'h39;
         4'hD: glyph = 7'h5E;
         4'hE: glyph = 7'h79;
         default: glyph = 7'h71;
      endcase
   endfunction

   // One double-dabble step: add 3 to nibbles >= 5, then shift {bcd,bin} left.
   always_comb begin
      bcd_adj = bcd_q;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) begin
            bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
         end
      end
      {carry, bcd_step, bin_step} = {bcd_adj, bin_q, 1'b0};
   end

   // Handshake / conversion FSM next-state logic.
   always_comb begin
      state_d    = state_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      shown_d    = shown_q;
      dp_d       = dp_q;
      dpl_d      = dpl_q;
      overflow_d = overflow_q;
      dec_d      = dec_q;
      case (state_q)
         S_IDLE: begin
            if (load) begin
               if (mode_dec) begin
                  state_d = S_CONV;
                  bin_d   = value;
                  bcd_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
                  dpl_d   = dp_mask;
               end else begin
                  shown_d    = value;
                  dp_d       = dp_mask;
                  overflow_d = 1'b0;
                  dec_d      = 1'b0;
               end
            end
         end
         S_CONV: begin
            bin_d = bin_step;
            bcd_d = bcd_step;
            ovf_d = ovf_q | carry;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) begin
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            shown_d    = bcd_q;
            overflow_d = ovf_q;
            dp_d       = dpl_q;
            dec_d      = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM and display-content registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         bin_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         shown_q    <= '0;
         dp_q       <= '0;
         dpl_q      <= '0;
         overflow_q <= 1'b0;
         dec_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         shown_q    <= shown_d;
         dp_q       <= dp_d;
         dpl_q      <= dpl_d;
         overflow_q <= overflow_d;
         dec_q      <= dec_d;
      end
   end

   // Free-running scan divider; the digit index advances on each wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q     <= '0;
         idx_q     <= '0;
         started_q <= 1'b0;
      end else begin
         div_q <= div_q + 1'b1;
         if (&div_q) begin
            started_q <= 1'b1;
            idx_q     <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
         end
      end
   end

`ifdef SEG_LEADING_ZERO_BLANK_EN
   logic [NUM_DIGITS-1:0] lz;

   // lz[k]: digits k..top are all zero.
   always_comb begin
      lz = '0;
      lz[NUM_DIGITS-1] = (shown_q[W-1 -: 4] == 4'd0);
      for (int unsigned j = 1; j < NUM_DIGITS; j++) begin
         lz[NUM_DIGITS-1-j] = lz[NUM_DIGITS-j] && (shown_q[4*(NUM_DIGITS-1-j) +: 4] == 4'd0);
      end
   end

   assign blank = dec_q && !overflow_q && (idx_q != '0) && lz[idx_q];
`else
   assign blank = 1'b0;
`endif

   // Active-high segment, dp and anode generation for the scanned digit.
   always_comb begin
      cur_nib = shown_q[{idx_q, 2'b00} +: 4];
      cur_dp  = dp_q[idx_q];
      seg_ah  = '0;
      dp_ah   = 1'b0;
      dig_ah  = '0;
      if (started_q && !blank) begin
         dig_ah[idx_q] = 1'b1;
         if (overflow_q) begin
            seg_ah = 7'h40;
         end else begin
            seg_ah = glyph(cur_nib);
            dp_ah  = cur_dp;
         end
      end
   end

   assign ready   = (state_q == S_IDLE);
   assign display = seg_ah ^ {7{ACTIVE_LOW}};
   assign dp      = dp_ah ^ ACTIVE_LOW;
   assign digit   = dig_ah ^ {NUM_DIGITS{ACTIVE_LOW}};

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl: a 4-digit active-low instance and a 6-digit
// active-high instance, both with a 4-cycle scan slot. Expected per-digit
// outputs are queued at load time and compared when each digit's slot is scanned.
module tb_seg7_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [15:0] v4 = '0;
   logic        md4 = 1'b0;
   logic [3:0]  dpm4 = '0;
   logic        ld4 = 1'b0;
   logic        rdy4;
   logic [6:0]  disp4;
   logic        dp4;
   logic [3:0]  dig4;

   logic [23:0] v6 = '0;
   logic        md6 = 1'b0;
   logic [5:0]  dpm6 = '0;
   logic        ld6 = 1'b0;
   logic        rdy6;
   logic [6:0]  disp6;
   logic        dp6;
   logic [5:0]  dig6;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         dig;
      logic [6:0] seg;
      logic       dpx;
      logic       en;
   } exp_t;

   exp_t sb[$];

   // Reference scan position: digit advances every 4 cycles from reset.
   logic [1:0] mdiv;
   logic [1:0] m4;
   logic [2:0] m6;
   logic       mst;

   always #5 clk = ~clk;

   seg7_scan_ctrl #(.NUM_DIGITS(4), .SCAN_DIV_BITS(2), .ACTIVE_LOW(1)) dut4 (
      .clk(clk), .rst(rst), .value(v4), .mode_dec(md4), .dp_mask(dpm4), .load(ld4),
      .ready(rdy4), .display(disp4), .dp(dp4), .digit(dig4));

   seg7_scan_ctrl #(.NUM_DIGITS(6), .SCAN_DIV_BITS(2), .ACTIVE_LOW(0)) dut6 (
      .clk(clk), .rst(rst), .value(v6), .mode_dec(md6), .dp_mask(dpm6), .load(ld6),
      .ready(rdy6), .display(disp6), .dp(dp6), .digit(dig6));

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mdiv <= 2'd0; m4 <= 2'd0; m6 <= 3'd0; mst <= 1'b0;
      end else begin
         mdiv <= mdiv + 2'd1;
         if (mdiv == 2'd3) begin
            mst <= 1'b1;
            m4  <= (m4 == 2'd3) ? 2'd0 : m4 + 2'd1;
            m6  <= (m6 == 3'd5) ? 3'd0 : m6 + 3'd1;
         end
      end
   end

   function automatic logic [6:0] ref_glyph(input int n);
      case (n)
         0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
         4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
         8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
         12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
      endcase
   endfunction

   task automatic push_expect(input int which, input longint val, input bit dec, input logic [7:0] mask);
      int     n;
      longint lim;
      bit     ovf;
      n   = which ? 6 : 4;
      lim = 1;
      for (int i = 0; i < n; i++) lim = lim * 10;
      ovf = dec && (val >= lim);
      for (int k = 0; k < n; k++) begin
         exp_t   e;
         int     d;
         longint p;
         p = 1;
         for (int j = 0; j < k; j++) p = p * 10;
         e.dig = k;
         e.en  = 1'b1;
         if (ovf) begin
            e.seg = 7'h40;
            e.dpx = 1'b0;
         end else begin
            d     = dec ? int'((val / p) % 10) : int'((val >> (4 * k)) & 15);
            e.seg = ref_glyph(d);
            e.dpx = mask[k];
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if (dec && k > 0 && (val / p) == 0) begin
               e.en  = 1'b0;
               e.dpx = 1'b0;
               e.seg = 7'h00;
            end
`endif
         end
         sb.push_back(e);
      end
   endtask

   task automatic do_load(input int which, input longint val, input bit dec, input logic [7:0] mask);
      @(negedge clk);
      if (which != 0) begin
         v6 = val[23:0]; md6 = dec; dpm6 = mask[5:0]; ld6 = 1'b1;
      end else begin
         v4 = val[15:0]; md4 = dec; dpm4 = mask[3:0]; ld4 = 1'b1;
      end
      push_expect(which, val, dec, mask);
      @(negedge clk);
      ld4 = 1'b0;
      ld6 = 1'b0;
   endtask

   task automatic wait_ready(input int which, input string nm);
      int n;
      n = 0;
      while (((which != 0) ? rdy6 : rdy4) !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 100) begin
         errors++;
         $display("FAIL %s ready timeout: got %b want 1", nm, (which != 0) ? rdy6 : rdy4);
      end
   endtask

   task automatic check_display(input int which, input string nm);
      exp_t       e;
      int         n;
      logic [7:0] exp_dig, obs_dig;
      logic [6:0] exp_seg, obs_seg;
      logic       exp_dp, obs_dp;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n = 0;
         while (!(mst && (((which != 0) ? int'(m6) : int'(m4)) == e.dig)) && n < 200) begin
            @(negedge clk);
            n++;
         end
         checks++;
         if (n >= 200) begin
            errors++;
            $display("FAIL %s slot%0d timeout: got none want slot", nm, e.dig);
         end else begin
            exp_dig = e.en ? 8'(1 << e.dig) : 8'h00;
            exp_seg = e.seg;
            exp_dp  = e.dpx;
            if (which == 0) begin
               exp_dig = {4'h0, ~exp_dig[3:0]};
               exp_seg = ~exp_seg;
               exp_dp  = ~exp_dp;
               obs_dig = {4'h0, dig4};
               obs_seg = disp4;
               obs_dp  = dp4;
            end else begin
               obs_dig = {2'b00, dig6};
               obs_seg = disp6;
               obs_dp  = dp6;
            end
            if (obs_dig !== exp_dig) begin
               errors++;
               $display("FAIL %s digit%0d anodes: got %b want %b", nm, e.dig, obs_dig, exp_dig);
            end
            checks++;
            if (obs_dp !== exp_dp) begin
               errors++;
               $display("FAIL %s digit%0d dp: got %b want %b", nm, e.dig, obs_dp, exp_dp);
            end
            if (e.en) begin
               checks++;
               if (obs_seg !== exp_seg) begin
                  errors++;
                  $display("FAIL %s digit%0d segs: got %h want %h", nm, e.dig, obs_seg, exp_seg);
               end
            end
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      @(negedge clk);
      checks += 6;
      if (rdy4 !== 1'b1)    begin errors++; $display("FAIL reset ready4: got %b want 1", rdy4); end
      if (dig4 !== 4'hF)    begin errors++; $display("FAIL reset digit4: got %b want 1111", dig4); end
      if (disp4 !== 7'h7F)  begin errors++; $display("FAIL reset display4: got %h want 7f", disp4); end
      if (dp4 !== 1'b1)     begin errors++; $display("FAIL reset dp4: got %b want 1", dp4); end
      if (dig6 !== 6'h00)   begin errors++; $display("FAIL reset digit6: got %b want 000000", dig6); end
      if (disp6 !== 7'h00)  begin errors++; $display("FAIL reset display6: got %h want 00", disp6); end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (dig4 !== 4'hF) begin errors++; $display("FAIL prewrap digit4: got %b want 1111", dig4); end
   endtask

   task automatic test_hex;
      do_load(0, 64'h1A2F, 1'b0, 8'h00);
      check_display(0, "hex_1A2F");
   endtask

   task automatic test_dec;
      int cnt;
      do_load(0, 1234, 1'b1, 8'h00);
      cnt = 0;
      for (int i = 0; i < 60; i++) begin
         if (rdy4) break;
         cnt++;
         if (cnt == 5) begin ld4 = 1'b1; v4 = 16'd9999; md4 = 1'b1; end
         if (cnt == 6) ld4 = 1'b0;
         @(negedge clk);
      end
      checks++;
      if (cnt != 17) begin errors++; $display("FAIL dec_latency: got %0d want 17", cnt); end
      check_display(0, "dec_1234");
   endtask

   task automatic test_overflow;
      do_load(0, 10000, 1'b1, 8'h0F);
      wait_ready(0, "ovf_10000");
      check_display(0, "ovf_10000");
      do_load(0, 0, 1'b0, 8'h00);
      check_display(0, "ovf_clear");
   endtask

   task automatic test_dp;
      do_load(0, 42, 1'b1, 8'h02);
      wait_ready(0, "dp_42");
      check_display(0, "dp_42");
   endtask

   task automatic test_reset_mid;
      do_load(0, 5678, 1'b1, 8'h00);
      sb.delete();
      repeat (8) @(negedge clk);
      rst = 1'b1;
      #1;
      checks += 3;
      if (rdy4 !== 1'b1)   begin errors++; $display("FAIL midrst ready: got %b want 1", rdy4); end
      if (dig4 !== 4'hF)   begin errors++; $display("FAIL midrst digit: got %b want 1111", dig4); end
      if (disp4 !== 7'h7F) begin errors++; $display("FAIL midrst display: got %h want 7f", disp4); end
      @(negedge clk);
      rst = 1'b0;
      do_load(0, 77, 1'b1, 8'h00);
      wait_ready(0, "midrst_77");
      check_display(0, "midrst_77");
   endtask

   task automatic test_wide;
      do_load(1, 999999, 1'b1, 8'h00);
      wait_ready(1, "wide_999999");
      check_display(1, "wide_999999");
   endtask

   initial begin
      test_reset();
      test_hex();
      test_dec();
      test_overflow();
      test_dp();
      test_reset_mid();
      test_wide();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
